// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: each stage resolves one CHUNK-bit slice, so latency is WIDTH/CHUNK edges.
// Stages hold under backpressure, empty stages still accept, and a full pipe pops and pushes in the same cycle.
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int STAGES = WIDTH / CHUNK;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_cfg
         $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   logic             vld [STAGES];
   logic             rdy [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             ov_q;

   // Stage k can move when any stage from k upward is empty or the sink accepts;
   // expanding the chain this way keeps it free of self-referencing nets.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         rdy[k] = out_ready;
         for (int j = k; j < STAGES; j++) begin
            if (!vld[j]) rdy[k] = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             v_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic             c_in;
      logic [WIDTH-1:0] s_nxt;
      logic [CHUNK:0]   part;

      if (k == 0) begin : g_head
         assign v_in = in_valid;
         assign a_in = a;
         assign b_in = sub ? ~b : b;
         assign c_in = sub | carry_in;
         assign s_in = '0;
      end else begin : g_body
         assign v_in = vld[k-1];
         assign a_in = a_q[k-1];
         assign b_in = b_q[k-1];
         assign c_in = c_q[k-1];
         assign s_in = s_q[k-1];
      end

      assign part = {1'b0, a_in[k*CHUNK +: CHUNK]}
                  + {1'b0, b_in[k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c_in};

      always_comb begin
         s_nxt = s_in;
         s_nxt[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      end

      // Payload only loads on a real transfer so the last stage keeps its
      // previous result visible while its valid bit is low.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end else if (rdy[k]) begin
            vld[k] <= v_in;
            if (v_in) begin
               a_q[k] <= a_in;
               b_q[k] <= b_in;
               s_q[k] <= s_nxt;
               c_q[k] <= part[CHUNK];
            end
         end
      end

      if (k == STAGES - 1) begin : g_tail
         always_ff @(posedge clk) begin
            if (rst) begin
               ov_q <= 1'b0;
            end else if (rdy[k] && v_in) begin
               ov_q <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s_nxt[WIDTH-1] != a_in[WIDTH-1]);
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign carry_out = c_q[STAGES-1];
   assign overflow  = ov_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 16/4 instance against a queue-based reference, plus 32/32 and 32/8 instances.
module tb_pipelined_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, sub, carry_in, out_valid, out_ready, carry_out, overflow;
   logic [15:0] a, b, sum;

   logic        w_in_valid, w_in_ready, w_out_valid, w_carry_out, w_overflow;
   logic [31:0] w_a, w_b, w_sum;
   logic        n_in_valid, n_in_ready, n_out_valid, n_carry_out, n_overflow, n_sub;
   logic [31:0] n_a, n_b, n_sum;

   pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .sub(sub), .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry_out(carry_out), .overflow(overflow));

   pipelined_adder #(.WIDTH(32), .CHUNK(32)) dut_w (
      .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
      .sub(1'b0), .carry_in(1'b0), .out_valid(w_out_valid), .out_ready(1'b1),
      .sum(w_sum), .carry_out(w_carry_out), .overflow(w_overflow));

   pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut_n (
      .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .a(n_a), .b(n_b),
      .sub(n_sub), .carry_in(1'b0), .out_valid(n_out_valid), .out_ready(1'b1),
      .sum(n_sum), .carry_out(n_carry_out), .overflow(n_overflow));

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          pop_cnt = 0;
   int          first_pop = -1;
   int          last_pop = -1;
   int          acc_cnt = 0;
   int          ghost = 0;
   logic [17:0] sbq [$];

   // Reference result packed as {overflow, carry_out, sum}.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic s, input logic ci);
      logic [15:0] be;
      logic        c0;
      logic [16:0] full;
      logic        ovf;
      be   = s ? ~y : y;
      c0   = s | ci;
      full = {1'b0, x} + {1'b0, be} + {16'd0, c0};
      ovf  = (x[15] == be[15]) && (full[15] != x[15]);
      return {ovf, full[16], full[15:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic sel_ov(input int w);
      case (w)
         0:       return out_valid;
         1:       return w_out_valid;
         default: return n_out_valid;
      endcase
   endfunction

   // Called at a negedge with inputs already driven; scores the handshakes of the coming edge.
   task automatic cycle();
      logic [17:0] e;
      #1;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               ghost++;
            end else begin
               e = sbq.pop_front();
               check("result", 64'({overflow, carry_out, sum}), 64'(e));
               pop_cnt++;
               if (first_pop < 0) first_pop = cyc;
               last_pop = cyc;
            end
         end
         if (in_valid && in_ready) begin
            sbq.push_back(model(a, b, sub, carry_in));
            acc_cnt++;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   // Counts edges from the acceptance edge (already taken) until out_valid is seen.
   task automatic wait_lat(input int which, input int exp, input string tag);
      int n;
      n = 1;
      while (!sel_ov(which) && n < 20) begin
         cycle();
         n++;
      end
      check(tag, 64'(n), 64'(exp));
   endtask

   task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic ci, input logic [17:0] exp_res);
      in_valid = 1'b1; a = x; b = y; sub = s; carry_in = ci; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      wait_lat(0, 4, {tag, "_latency"});
      cycle();
      check({tag, "_hold"}, 64'({overflow, carry_out, sum}), 64'(exp_res));
      check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; carry_in = 1'b0;
      w_in_valid = 1'b0; w_a = '0; w_b = '0;
      n_in_valid = 1'b0; n_a = '0; n_b = '0; n_sub = 1'b0;
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_sum", 64'(sum), 64'(0));
      check("reset_carry_out", 64'(carry_out), 64'(0));
      check("reset_overflow", 64'(overflow), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);

      run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
      run_one("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
      run_one("carry_chain", 16'h0FFF, 16'h0000, 1'b0, 1'b1, 18'h01000);
      run_one("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 18'h0FFFE);
      run_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF);

      // Back-to-back with the sink always ready.
      pop_cnt = 0; first_pop = -1; last_pop = -1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         sub = 1'($urandom_range(0, 1)); carry_in = 1'($urandom_range(0, 1));
         cycle();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      check("b2b_count", 64'(pop_cnt), 64'(8));
      check("b2b_no_bubbles", 64'(last_pop - first_pop), 64'(7));
      check("b2b_drained", 64'(sbq.size()), 64'(0));

      // Stall the sink: exactly four accepts fill the pipe.
      acc_cnt = 0; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         sub = 1'($urandom_range(0, 1)); carry_in = 1'($urandom_range(0, 1));
         cycle();
      end
      #1;
      check("bp_accepts", 64'(acc_cnt), 64'(4));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      for (int i = 0; i < 3; i++) begin
         check("bp_stable", 64'({overflow, carry_out, sum}), 64'(sbq[0]));
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      check("full_push_pop", 64'(acc_cnt), 64'(5));
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) cycle();
      check("bp_drained", 64'(sbq.size()), 64'(0));

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'b0; carry_in = 1'b0;
         cycle();
      end
      in_valid = 1'b0; rst = 1'b1;
      cycle();
      rst = 1'b0;
      sbq.delete();
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_sum", 64'(sum), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      for (int i = 0; i < 8; i++) cycle();
      check("no_ghost_results", 64'(ghost), 64'(0));

      // Wider configurations.
      w_in_valid = 1'b1; w_a = 32'hFFFF_FFFF; w_b = 32'h0000_0001;
      cycle();
      w_in_valid = 1'b0;
      wait_lat(1, 1, "w32c32_latency");
      check("w32c32_result", 64'({w_overflow, w_carry_out, w_sum}), 64'({1'b0, 1'b1, 32'h0000_0000}));

      n_in_valid = 1'b1; n_a = 32'hFFFF_FFFF; n_b = 32'h0000_0001; n_sub = 1'b0;
      cycle();
      n_in_valid = 1'b0;
      wait_lat(2, 4, "w32c8_latency");
      check("w32c8_result", 64'({n_overflow, n_carry_out, n_sum}), 64'({1'b0, 1'b1, 32'h0000_0000}));

      n_in_valid = 1'b1; n_a = 32'h0000_0000; n_b = 32'h0000_0001; n_sub = 1'b1;
      cycle();
      n_in_valid = 1'b0;
      wait_lat(2, 4, "w32c8_sub_latency");
      check("w32c8_sub_result", 64'({n_overflow, n_carry_out, n_sum}), 64'({1'b0, 1'b0, 32'hFFFF_FFFF}));

      for (int i = 0; i < 4; i++) cycle();
      check("final_queue_empty", 64'(sbq.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined two's-complement add/subtract unit built from carry-chained chunks.
- Each pipeline stage resolves one CHUNK-bit slice and registers the carry into the next stage.
- Valid/ready handshakes on both sides; full throughput of one operation per cycle.
- Serves as the wide adder primitive for accumulators and datapath arithmetic in the transformer datapath.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits resolved per pipeline stage. WIDTH must be a multiple of CHUNK; otherwise it is an elaboration error.
- STAGES, WIDTH/CHUNK (derived, localparam), number of pipeline stages S.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept the operand bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 computes a+b+carry_in; 1 computes a-b.
- carry_in  in  1  carry into bit 0; ignored when sub=1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- carry_out  out  1  carry out of bit WIDTH-1. For sub=1, carry_out=1 means no borrow.
- overflow  out  1  signed overflow of the operation.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - All stage valid bits clear; out_valid=0.
  - sum, carry_out and overflow are driven 0.
  - in_ready follows the ready rule below, so it reads 1 whenever out_valid=0.
- Effective operands:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : carry_in.
  - The result is a + b_eff + cin_eff, computed modulo 2^WIDTH.
- Stage structure:
  - Stage k (0..S-1) adds bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1; stage 0 uses cin_eff.
  - Unprocessed upper operand bits and already-computed lower sum bits travel with each stage.
  - Each stage has its own valid bit.
- Handshake and timing:
  - Transfer occurs when valid && ready on the same edge.
  - ready_k = !valid_k || ready_{k+1}; ready_S = out_ready; in_ready = ready_0.
  - in_ready is combinational through this chain, and the chain has no combinational loops.
- Latency:
  - An operation accepted at edge n is presented with out_valid=1 starting after edge n+S-1, i.e. S edges including the acceptance edge.
  - With CHUNK=WIDTH (S=1) the result appears after the acceptance edge.
- Throughput:
  - With out_ready held 1, back-to-back accepts yield back-to-back results in order, with no bubbles.
- Backpressure:
  - While out_valid=1 and out_ready=0, sum, carry_out and overflow hold stable.
  - Stages fill; in_ready drops only when every stage holds valid data.
  - Bubbles collapse: an empty stage accepts even when its successor is stalled.
- Overflow:
  - overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb), evaluated on the final result.
  - overflow is registered together with sum.
- Simultaneous events:
  - A pop at the output and a push at the input in the same cycle are both honoured when the pipeline is full.
  - rst=1 overrides any handshake in that cycle.
- Reset mid-operation:
  - All in-flight operations are discarded and nothing is emitted afterwards.
  - Outputs take their reset values on the following edge.
- Invalid slots: when valid=0, the contents of a stage are don't-care, but the outputs must stay at their last transferred or reset values.

Test Plan (WIDTH=16, CHUNK=4, S=4 unless noted):
- Add wrap: a=0xFFFF, b=0x0001, sub=0, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0; out_valid rises after the 4th edge counted from acceptance.
- Signed overflow and carry chaining: a=0x7FFF, b=0x0001 -> 0x8000, carry_out=0, overflow=1. Then a=0x0FFF, b=0x0000, carry_in=1 -> 0x1000.
- Subtract: a=0x0005, b=0x0007, sub=1 -> 0xFFFE, carry_out=0, overflow=0. Then a=0x8000, b=0x0001, sub=1 -> 0x7FFF, carry_out=1, overflow=1.
- Throughput and backpressure:
  - 8 back-to-back random operations with out_ready=1 -> 8 consecutive in-order results matching a reference model.
  - Then hold out_ready=0 -> in_ready drops after exactly 4 accepts; outputs stay stable; releasing out_ready drains the pipeline in order.
- Reset mid-flight: accept 3 operations, assert rst for 1 cycle -> out_valid=0, sum=0, and none of the 3 results ever appear.
- Config sweep: WIDTH=32 with CHUNK=32 and CHUNK=8 -> 1-cycle and 4-cycle latency respectively; 0xFFFFFFFF+1 -> 0x00000000, carry_out=1.
